// File: rtl/keypad_scanner_if.sv
//==============================================================================
// Module      : keypad_scanner_if
// Description : Keypad pins, power enable and accepted-key outputs of the scanner.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface keypad_scanner_if;
    logic       power;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  power,
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output power,
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

`default_nettype wire

// File: rtl/keypad_scanner.sv
//==============================================================================
// Module      : keypad_scanner
// Description : 4x4 active-low keypad scanner with frame-based press/release debounce.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module keypad_scanner #(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 3
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    keypad_scanner_if.master bus
);
    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DB_LAST  = 4'(DEBOUNCE);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DB_PRESS = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_DB_REL   = 2'd3;

    localparam logic [1:0] F_NONE  = 2'd0;
    localparam logic [1:0] F_KEY   = 2'd1;
    localparam logic [1:0] F_MULTI = 2'd2;

    logic [3:0]       row_meta, row_sync;
    logic [DIV_W-1:0] div;
    logic [1:0]       col_idx;
    logic             acc_hit, acc_multi;
    logic [3:0]       acc_code;
    logic [1:0]       state, state_nxt;
    logic [3:0]       cnt, cnt_nxt, cand, cand_nxt, key_code_q;
    logic             key_valid_q, accept;
    logic [2:0]       low_count;
    logic [1:0]       sample_row;
    logic             sample_one, sample_multi, tc, eval, match;
    logic             frame_hit, frame_multi;
    logic [3:0]       frame_code;
    logic [1:0]       frame_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= bus.row;
            row_sync <= row_meta;
        end
    end

    // Per-column sample decode merged with the running frame accumulator
    always_comb begin
        low_count  = 3'd0;
        sample_row = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!row_sync[i]) begin
                low_count  = low_count + 3'd1;
                sample_row = 2'(i);
            end
        end
        sample_one   = (low_count == 3'd1);
        sample_multi = (low_count > 3'd1);
        frame_hit    = acc_hit | sample_one;
        frame_multi  = acc_multi | sample_multi | (acc_hit & sample_one);
        frame_code   = sample_one ? {sample_row, col_idx} : acc_code;
        frame_res    = frame_multi ? F_MULTI : (frame_hit ? F_KEY : F_NONE);
        tc           = (div == DIV_LAST);
        eval         = bus.power & tc & (col_idx == 2'd3);
        match        = (frame_res == F_KEY) && (frame_code == cand);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '0;
            col_idx   <= 2'd0;
            acc_hit   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= 4'd0;
        end else if (!bus.power) begin
            div       <= '0;
            col_idx   <= 2'd0;
            acc_hit   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= 4'd0;
        end else if (tc) begin
            div     <= '0;
            col_idx <= col_idx + 2'd1;
            if (col_idx == 2'd3) begin
                acc_hit   <= 1'b0;
                acc_multi <= 1'b0;
                acc_code  <= 4'd0;
            end else begin
                acc_hit   <= frame_hit;
                acc_multi <= frame_multi;
                acc_code  <= frame_code;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            cand        <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
        end else if (!bus.power) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cand        <= cand_nxt;
            key_valid_q <= accept;
            if (accept) key_code_q <= cand;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        accept    = 1'b0;
        if (eval) begin
            case (state)
                S_IDLE: begin
                    if (frame_res == F_KEY) begin
                        state_nxt = S_DB_PRESS;
                        cand_nxt  = frame_code;
                        cnt_nxt   = 4'd1;
                    end
                end
                S_DB_PRESS: begin
                    if (!match) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = 4'd0;
                    end else if (cnt + 4'd1 == DB_LAST) begin
                        state_nxt = S_PRESSED;
                        cnt_nxt   = 4'd0;
                        accept    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                S_PRESSED: begin
                    if (!match) begin
                        state_nxt = S_DB_REL;
                        cnt_nxt   = 4'd1;
                    end
                end
                S_DB_REL: begin
                    if (match) begin
                        state_nxt = S_PRESSED;
                        cnt_nxt   = 4'd0;
                    end else if (cnt + 4'd1 == DB_LAST) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = 4'd0;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Gated by power so the outputs go quiet on the same cycle power drops
    always_comb begin
        bus.col       = bus.power ? ~(4'b0001 << col_idx) : 4'b1111;
        bus.key_code  = key_code_q;
        bus.key_valid = bus.power & key_valid_q;
        bus.key_held  = bus.power & ((state == S_PRESSED) || (state == S_DB_REL));
    end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
//==============================================================================
// Module      : tb_keypad_scanner
// Description : Directed frame-aligned vectors against a 4x4 keypad matrix model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int NVEC     = 25;

    typedef struct {
        logic        power;
        logic [15:0] keys;
        int          frames;
        logic        pre_reset;
        int          exp_pulses;
        logic        exp_valid;
        logic        exp_held;
        logic [3:0]  exp_code;
        logic [3:0]  exp_col;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] keys;
    int          applied;
    int          miscompares;
    int          pulses;
    int          doubles;
    int          cur;
    logic        prev_valid;
    vec_t        vecs [NVEC];

    keypad_scanner_if bus ();

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key index r*4+c pulls row r low while column c is driven low
    always_comb begin
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (!bus.col[ci] && keys[ri*4+ci]) r[ri] = 1'b0;
        bus.row = r;
    end

    task automatic check(input string name, input int act, input int exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (vector %0d): got %0h, expected %0h", name, cur, act, exp);
        end
    endtask

    task automatic step_frames(input int n);
        repeat (n * FRAME) begin
            @(posedge clk);
            #1;
            if (bus.key_valid) begin
                pulses++;
                if (prev_valid) doubles++;
            end
            prev_valid = bus.key_valid;
        end
    endtask

    task automatic check_reset_state();
        check("reset_col", int'(bus.col), 'hE);
        check("reset_code", int'(bus.key_code), 0);
        check("reset_valid", int'(bus.key_valid), 0);
        check("reset_held", int'(bus.key_held), 0);
    endtask

    initial begin
        applied = 0; miscompares = 0; pulses = 0; doubles = 0; cur = -1;
        prev_valid = 1'b0;

        //           pwr   keys      frm rst   pls val   held  code  col
        vecs[0]  = '{1'b1, 16'h0000, 2, 1'b0, 0, 1'b0, 1'b0, 4'h0, 4'hE};
        vecs[1]  = '{1'b1, 16'h0040, 2, 1'b0, 0, 1'b0, 1'b0, 4'h0, 4'hE};
        vecs[2]  = '{1'b1, 16'h0040, 1, 1'b0, 1, 1'b1, 1'b1, 4'h6, 4'hE};
        vecs[3]  = '{1'b1, 16'h0040, 1, 1'b0, 0, 1'b0, 1'b1, 4'h6, 4'hE};
        vecs[4]  = '{1'b1, 16'h0000, 1, 1'b0, 0, 1'b0, 1'b1, 4'h6, 4'hE};
        vecs[5]  = '{1'b1, 16'h0040, 1, 1'b0, 0, 1'b0, 1'b1, 4'h6, 4'hE};
        vecs[6]  = '{1'b1, 16'h0000, 2, 1'b0, 0, 1'b0, 1'b1, 4'h6, 4'hE};
        vecs[7]  = '{1'b1, 16'h0000, 1, 1'b0, 0, 1'b0, 1'b0, 4'h6, 4'hE};
        vecs[8]  = '{1'b1, 16'h0040, 1, 1'b0, 0, 1'b0, 1'b0, 4'h6, 4'hE};
        vecs[9]  = '{1'b1, 16'h0000, 1, 1'b0, 0, 1'b0, 1'b0, 4'h6, 4'hE};
        vecs[10] = '{1'b1, 16'h0040, 1, 1'b0, 0, 1'b0, 1'b0, 4'h6, 4'hE};
        vecs[11] = '{1'b1, 16'h0000, 1, 1'b0, 0, 1'b0, 1'b0, 4'h6, 4'hE};
        vecs[12] = '{1'b1, 16'h0040, 2, 1'b0, 0, 1'b0, 1'b0, 4'h6, 4'hE};
        vecs[13] = '{1'b1, 16'h0040, 1, 1'b0, 1, 1'b1, 1'b1, 4'h6, 4'hE};
        vecs[14] = '{1'b1, 16'h0000, 3, 1'b0, 0, 1'b0, 1'b0, 4'h6, 4'hE};
        vecs[15] = '{1'b1, 16'h0021, 10, 1'b0, 0, 1'b0, 1'b0, 4'h6, 4'hE};
        vecs[16] = '{1'b1, 16'h0001, 2, 1'b0, 0, 1'b0, 1'b0, 4'h6, 4'hE};
        vecs[17] = '{1'b1, 16'h0001, 1, 1'b0, 1, 1'b1, 1'b1, 4'h0, 4'hE};
        vecs[18] = '{1'b1, 16'h0000, 3, 1'b0, 0, 1'b0, 1'b0, 4'h0, 4'hE};
        vecs[19] = '{1'b1, 16'h8000, 2, 1'b0, 0, 1'b0, 1'b0, 4'h0, 4'hE};
        vecs[20] = '{1'b0, 16'h8000, 2, 1'b0, 0, 1'b0, 1'b0, 4'h0, 4'hF};
        vecs[21] = '{1'b1, 16'h8000, 2, 1'b0, 0, 1'b0, 1'b0, 4'h0, 4'hE};
        vecs[22] = '{1'b1, 16'h8000, 1, 1'b0, 1, 1'b1, 1'b1, 4'hF, 4'hE};
        vecs[23] = '{1'b1, 16'h8000, 2, 1'b1, 0, 1'b0, 1'b0, 4'h0, 4'hE};
        vecs[24] = '{1'b1, 16'h8000, 1, 1'b0, 1, 1'b1, 1'b1, 4'hF, 4'hE};

        rst_n     = 1'b0;
        bus.power = 1'b1;
        keys      = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            cur = v;
            if (vecs[v].pre_reset) begin
                // Asynchronous reset in the middle of a frame while a key is held
                repeat (5) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                check_reset_state();
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                prev_valid = 1'b0;
            end
            bus.power = vecs[v].power;
            keys      = vecs[v].keys;
            pulses    = 0;
            #1;
            if (!vecs[v].power) check("col_power_off", int'(bus.col), 'hF);
            step_frames(vecs[v].frames);
            check("pulse_count", pulses, vecs[v].exp_pulses);
            check("key_valid", int'(bus.key_valid), int'(vecs[v].exp_valid));
            check("key_held", int'(bus.key_held), int'(vecs[v].exp_held));
            check("key_code", int'(bus.key_code), int'(vecs[v].exp_code));
            check("col", int'(bus.col), int'(vecs[v].exp_col));
        end

        cur = NVEC;
        check("valid_back_to_back", doubles, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
